// File: rtl/cp0_reg.sv
// ---------------------------------------------------------------------------
// cp0_reg -- MIPS-style Coprocessor-0 register file.
//
// Holds Count, Compare, Status, Cause and EPC. PRId and Config are constants.
// It takes the CP0 write port from write-back, serves MFC0 reads
// combinationally, applies exception and ERET updates from MEM, and raises
// the timer interrupt.
//
// Optional feature macro: CP0_TIMER_EN
//   defined   -> Count/Compare flops and timer_int_o are present.
//   undefined -> Count/Compare read 0 and their writes are ignored.
//                timer_int_o is tied to 0.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   we_i/waddr_i/data_i  CP0 write port (committed on the rising edge)
//   raddr_i / data_o     MFC0 read port (combinational, no write bypass)
//   int_i[5:0]           hardware interrupt lines, sampled into Cause[15:10]
//   excepttype_i         exception code from MEM (0 = none, 0xe = eret)
//   current_inst_addr_i  PC of the excepting instruction
//   is_in_delayslot_i    excepting instruction sits in a branch delay slot
//   *_o mirrors          current register values
//   timer_int_o          sticky timer interrupt request
// ---------------------------------------------------------------------------
module cp0_reg #(
  parameter logic [31:0] PRID_VALUE   = 32'h00480102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000,
  parameter logic [31:0] STATUS_RESET = 32'h10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;
  localparam logic [4:0] REG_CONFIG  = 5'd16;

  logic [31:0] count_reg;
  logic [31:0] compare_reg;
  logic [31:0] status_reg;
  logic [31:0] cause_reg;
  logic [31:0] epc_reg;
  logic        timer_int_reg;

  // Exception decode: which codes trap, and what ExcCode they record.
  logic       exc_valid;
  logic [4:0] exc_code;
  logic       eret;

  always_comb begin
    exc_valid = 1'b0;
    exc_code  = 5'd0;
    case (excepttype_i)
      32'h0000_0001: begin exc_valid = 1'b1; exc_code = 5'd0;  end
      32'h0000_0008: begin exc_valid = 1'b1; exc_code = 5'd8;  end
      32'h0000_000a: begin exc_valid = 1'b1; exc_code = 5'd10; end
      32'h0000_000d: begin exc_valid = 1'b1; exc_code = 5'd13; end
      32'h0000_000c: begin exc_valid = 1'b1; exc_code = 5'd12; end
      default:       begin exc_valid = 1'b0; exc_code = 5'd0;  end
    endcase
  end

  assign eret = (excepttype_i == 32'h0000_000e);

  // Status / Cause / EPC. Later non-blocking assignments in this block win.
  // So exception updates override a same-cycle software write on shared
  // fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_reg <= STATUS_RESET;
      cause_reg  <= 32'd0;
      epc_reg    <= 32'd0;
    end else begin
      if (we_i) begin
        case (waddr_i)
          REG_STATUS: status_reg <= data_i;
          REG_CAUSE: begin
            // Only IP[9:8] (software interrupts), WP and IV are writable.
            cause_reg[9:8]   <= data_i[9:8];
            cause_reg[23:22] <= data_i[23:22];
          end
          REG_EPC: epc_reg <= data_i;
          default: ;
        endcase
      end

      cause_reg[15:10] <= int_i;

      if (exc_valid) begin
        // A nested exception (EXL already set) keeps the original EPC and BD.
        if (!status_reg[1]) begin
          epc_reg      <= is_in_delayslot_i ? (current_inst_addr_i - 32'd4)
                                            : current_inst_addr_i;
          cause_reg[31] <= is_in_delayslot_i;
        end
        status_reg[1]  <= 1'b1;
        cause_reg[6:2] <= exc_code;
      end else if (eret) begin
        status_reg[1] <= 1'b0;
      end
    end
  end

`ifdef CP0_TIMER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg     <= 32'd0;
      compare_reg   <= 32'd0;
      timer_int_reg <= 1'b0;
    end else begin
      // A software write to Count replaces this cycle's increment.
      if (we_i && waddr_i == REG_COUNT) begin
        count_reg <= data_i;
      end else begin
        count_reg <= count_reg + 32'd1;
      end

      // Writing Compare is the only way to acknowledge the timer interrupt.
      // The write also wins over a match seen in the same cycle.
      if (we_i && waddr_i == REG_COMPARE) begin
        compare_reg   <= data_i;
        timer_int_reg <= 1'b0;
      end else if (compare_reg != 32'd0 && count_reg == compare_reg) begin
        timer_int_reg <= 1'b1;
      end
    end
  end
`else
  assign count_reg     = 32'd0;
  assign compare_reg   = 32'd0;
  assign timer_int_reg = 1'b0;
`endif

  // MFC0 read port: registered values only.
  // A same-cycle write is forwarded elsewhere.
  always_comb begin
    data_o = 32'd0;
    case (raddr_i)
      REG_COUNT:   data_o = count_reg;
      REG_COMPARE: data_o = compare_reg;
      REG_STATUS:  data_o = status_reg;
      REG_CAUSE:   data_o = cause_reg;
      REG_EPC:     data_o = epc_reg;
      REG_PRID:    data_o = PRID_VALUE;
      REG_CONFIG:  data_o = CONFIG_VALUE;
      default:     data_o = 32'd0;
    endcase
  end

  assign count_o     = count_reg;
  assign compare_o   = compare_reg;
  assign status_o    = status_reg;
  assign cause_o     = cause_reg;
  assign epc_o       = epc_reg;
  assign config_o    = CONFIG_VALUE;
  assign prid_o      = PRID_VALUE;
  assign timer_int_o = timer_int_reg;

endmodule

// File: tb/tb_cp0_reg.sv
// ---------------------------------------------------------------------------
// tb_cp0_reg -- scoreboard bench for cp0_reg.
//
// The driver applies one stimulus per cycle at the falling edge.
// It advances a behavioural model and queues the expected register state
// for after the next rising edge (or immediately, for an asynchronous reset).
// A separate monitor pops and compares every time the DUT updates.
// ---------------------------------------------------------------------------
module tb_cp0_reg;

  localparam logic [31:0] PRID_C   = 32'h00480102;
  localparam logic [31:0] CONFIG_C = 32'h00008000;
  localparam logic [31:0] STATUS_C = 32'h10000000;
  localparam logic [31:0] CAUSE_WR = 32'h00C00300;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = 5'd0;
  logic [31:0] data = 32'd0;
  logic [4:0]  raddr = 5'd0;
  logic [5:0]  int_l = 6'd0;
  logic [31:0] exc = 32'd0;
  logic [31:0] addr = 32'd0;
  logic        ds = 1'b0;

  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o;
  logic [31:0] config_o, prid_o;
  logic        timer_int_o;

  cp0_reg dut (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .data_i(data),
    .raddr_i(raddr), .int_i(int_l), .excepttype_i(exc),
    .current_inst_addr_i(addr), .is_in_delayslot_i(ds),
    .data_o(data_o), .count_o(count_o), .compare_o(compare_o),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .config_o(config_o), .prid_o(prid_o), .timer_int_o(timer_int_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] count, compare, status, cause, epc, rdata;
    logic        timer;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad = 0;

  // Behavioural model state
  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
  logic        m_timer;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd9:  return m_count;
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return m_cause;
      5'd14: return m_epc;
      5'd15: return PRID_C;
      5'd16: return CONFIG_C;
      default: return 32'd0;
    endcase
  endfunction

  task automatic push_expect();
    exp_t e;
    e.count = m_count; e.compare = m_compare; e.status = m_status;
    e.cause = m_cause; e.epc = m_epc; e.timer = m_timer;
    e.rdata = m_read(raddr);
    sb_q.push_back(e);
  endtask

  task automatic model_reset();
    m_count = 0; m_compare = 0; m_status = STATUS_C;
    m_cause = 0; m_epc = 0; m_timer = 0;
  endtask

  // Next state after one rising edge, from the current inputs.
  task automatic model_step();
    logic [31:0] n_count, n_compare, n_status, n_cause, n_epc;
    logic n_timer;
    int code;
    bit is_exc;
`ifdef CP0_TIMER_EN
    n_count   = (we && waddr == 5'd9) ? data : m_count + 32'd1;
    n_compare = (we && waddr == 5'd11) ? data : m_compare;
    if (we && waddr == 5'd11) n_timer = 1'b0;
    else n_timer = m_timer || (m_compare != 0 && m_count == m_compare);
`else
    n_count = 0; n_compare = 0; n_timer = 1'b0;
`endif
    n_status = (we && waddr == 5'd12) ? data : m_status;
    n_epc    = (we && waddr == 5'd14) ? data : m_epc;
    n_cause  = m_cause;
    if (we && waddr == 5'd13) n_cause = (m_cause & ~CAUSE_WR) | (data & CAUSE_WR);
    n_cause[15:10] = int_l;
    is_exc = 1'b1;
    code = 0;
    case (exc)
      32'h1: code = 0;
      32'h8: code = 8;
      32'ha: code = 10;
      32'hc: code = 12;
      32'hd: code = 13;
      default: is_exc = 1'b0;
    endcase
    if (is_exc) begin
      if (m_status[1] == 1'b0) begin
        n_epc = ds ? addr - 32'd4 : addr;
        n_cause[31] = ds;
      end
      n_status[1] = 1'b1;
      n_cause[6:2] = code[4:0];
    end else if (exc == 32'he) begin
      n_status[1] = 1'b0;
    end
    m_count = n_count; m_compare = n_compare; m_timer = n_timer;
    m_status = n_status; m_cause = n_cause; m_epc = n_epc;
  endtask

  task automatic apply(input logic w, input logic [4:0] wa, input logic [31:0] d,
                       input logic [4:0] ra, input logic [5:0] il,
                       input logic [31:0] ex, input logic [31:0] ad, input logic dsl);
    we = w; waddr = wa; data = d; raddr = ra; int_l = il;
    exc = ex; addr = ad; ds = dsl;
    model_step();
    push_expect();
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] d,
                       input logic [4:0] ra, input logic [5:0] il,
                       input logic [31:0] ex, input logic [31:0] ad, input logic dsl);
    @(negedge clk);
    apply(w, wa, d, ra, il, ex, ad, dsl);
  endtask

  task automatic idle(input int n, input logic [4:0] ra, input logic [5:0] il);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 32'd0, ra, il, 32'd0, 32'd0, 1'b0);
  endtask

  // Asynchronous reset in the middle of a low clock phase.
  // The expectation is checked before any rising edge.
  task automatic do_reset();
    @(negedge clk);
    we = 1'b0; exc = 32'd0; raddr = 5'd15; int_l = 6'd0;
    #2;
    rst = 1'b1;
    model_reset();
    push_expect();
    @(negedge clk);
    rst = 1'b0;
    apply(1'b0, 5'd0, 32'd0, 5'd15, 6'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: the DUT presents new state on every rising clock or reset edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("count",   count_o,   e.count);
        check("compare", compare_o, e.compare);
        check("status",  status_o,  e.status);
        check("cause",   cause_o,   e.cause);
        check("epc",     epc_o,     e.epc);
        check("timer",   {31'd0, timer_int_o}, {31'd0, e.timer});
        check("data_o",  data_o,    e.rdata);
        check("prid",    prid_o,    PRID_C);
        check("config",  config_o,  CONFIG_C);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

  function automatic logic [4:0] pick_addr();
    logic [4:0] tbl [7];
    int r;
    tbl = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16};
    r = $urandom_range(0, 7);
    if (r == 7) return 5'($urandom_range(0, 31));
    return tbl[r];
  endfunction

  function automatic logic [31:0] pick_exc();
    int r;
    r = $urandom_range(0, 15);
    case (r)
      8: return 32'h1;
      9: return 32'h8;
      10: return 32'ha;
      11: return 32'hc;
      12: return 32'hd;
      13: return 32'he;
      14: return 32'h3;
      15: return 32'h10;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    logic [4:0] wa;
    logic [31:0] d;
    model_reset();
    do_reset();

    // Timer: Compare=20, Count=10, fires after the match, then a Compare
    // write acknowledges it.
    drive(1'b1, 5'd11, 32'd20, 5'd11, 6'd0, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 5'd9,  32'd10, 5'd9,  6'd0, 32'd0, 32'd0, 1'b0);
    idle(14, 5'd9, 6'd0);
    drive(1'b1, 5'd11, 32'd40, 5'd11, 6'd0, 32'd0, 32'd0, 1'b0);
    idle(2, 5'd11, 6'd0);

    // Cause write mask, then hardware interrupt sampling.
    drive(1'b1, 5'd13, 32'hFFFFFFFF, 5'd13, 6'd0, 32'd0, 32'd0, 1'b0);
    idle(1, 5'd13, 6'd0);
    idle(2, 5'd13, 6'b000101);

    // Syscall, not in a delay slot.
    drive(1'b0, 5'd0, 32'd0, 5'd14, 6'd0, 32'h8, 32'hBFC00100, 1'b0);
    // ERET
    drive(1'b0, 5'd0, 32'd0, 5'd12, 6'd0, 32'he, 32'd0, 1'b0);
    // Overflow in a delay slot, then a nested trap that keeps EPC.
    drive(1'b0, 5'd0, 32'd0, 5'd14, 6'd0, 32'hc, 32'h00000204, 1'b1);
    drive(1'b0, 5'd0, 32'd0, 5'd14, 6'd0, 32'hd, 32'h00000999, 1'b0);
    drive(1'b0, 5'd0, 32'd0, 5'd12, 6'd0, 32'he, 32'd0, 1'b0);
    // EPC write racing a syscall: the exception value wins.
    drive(1'b1, 5'd14, 32'h12345678, 5'd14, 6'd0, 32'h8, 32'h00400000, 1'b0);
    idle(1, 5'd14, 6'd0);

    // Randomized traffic, with occasional mid-run resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 60) == 0) begin
        do_reset();
      end else begin
        wa = pick_addr();
        d = $urandom();
        if (wa == 5'd11 && $urandom_range(0, 1) == 1) d = m_count + 32'($urandom_range(1, 6));
        drive(1'($urandom_range(0, 1)), wa, d, pick_addr(), 6'($urandom_range(0, 63)),
              pick_exc(), $urandom(), 1'($urandom_range(0, 1)));
      end
    end

    do_reset();
    idle(2, 5'd15, 6'd0);
    @(negedge clk);
    @(negedge clk);
    check("drain", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
